// File: rtl/dmem_pkg.sv
// dmem_pkg: shared types and helpers for the data-memory responder.
// Holds the funct3 access-size encoding, the responder FSM states and the
// legality check (alignment + size/direction) used to flag resp_err.
package dmem_pkg;

  // funct3 access-size encoding
  typedef enum logic [2:0] {
    SZ_B  = 3'b000,
    SZ_H  = 3'b001,
    SZ_W  = 3'b010,
    SZ_BU = 3'b100,
    SZ_HU = 3'b101
  } size_e;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    RESP = 2'd2
  } state_e;

  // 1 when the access can be performed; 0 means misaligned or illegal size.
  // Unsigned sizes only make sense for loads.
  function automatic logic is_legal(input logic [2:0] size,
                                    input logic       we,
                                    input logic [1:0] addr_lo);
    logic ok;
    case (size)
      SZ_B:    ok = 1'b1;
      SZ_H:    ok = ~addr_lo[0];
      SZ_W:    ok = (addr_lo == 2'b00);
      SZ_BU:   ok = ~we;
      SZ_HU:   ok = ~we & ~addr_lo[0];
      default: ok = 1'b0;
    endcase
    return ok;
  endfunction

endpackage

// File: rtl/dmem_lane_align.sv
// dmem_lane_align: byte-lane steering between a 32-bit word and sub-word accesses.
// Latency: purely combinational. Backpressure: none (no state).
// Ports: size_i/addr_lo_i select the access; wdata_i -> be_o/wdata_o (store
// side, data replicated across lanes); rword_i -> rdata_o (load side, extended).
module dmem_lane_align
  import dmem_pkg::*;
(
  input  logic [2:0]  size_i,
  input  logic [1:0]  addr_lo_i,
  input  logic [31:0] wdata_i,
  input  logic [31:0] rword_i,
  output logic [3:0]  be_o,
  output logic [31:0] wdata_o,
  output logic [31:0] rdata_o
);

  logic [31:0] shifted;

  // Store side: replicate the payload so every candidate lane already carries
  // the right bytes; the byte-enable picks which lanes actually change.
  always_comb begin
    be_o    = 4'b0000;
    wdata_o = wdata_i;
    case (size_i)
      SZ_B: begin
        be_o    = 4'b0001 << addr_lo_i;
        wdata_o = {4{wdata_i[7:0]}};
      end
      SZ_H: begin
        be_o    = addr_lo_i[1] ? 4'b1100 : 4'b0011;
        wdata_o = {2{wdata_i[15:0]}};
      end
      SZ_W: be_o = 4'b1111;
      default: be_o = 4'b0000;
    endcase
  end

  // Load side: bring the addressed lane down to bit 0, then extend.
  always_comb begin
    shifted = rword_i >> {addr_lo_i, 3'b000};
    rdata_o = '0;
    case (size_i)
      SZ_B:    rdata_o = {{24{shifted[7]}}, shifted[7:0]};
      SZ_H:    rdata_o = {{16{shifted[15]}}, shifted[15:0]};
      SZ_W:    rdata_o = shifted;
      SZ_BU:   rdata_o = {24'd0, shifted[7:0]};
      SZ_HU:   rdata_o = {16'd0, shifted[15:0]};
      default: rdata_o = '0;
    endcase
  end

endmodule

// File: rtl/dmem_responder.sv
// dmem_responder: multi-cycle data memory with valid/ready request and response channels.
// Latency: resp_valid sampled high WAIT_STATES+1 edges after the accept edge.
// Backpressure: resp_ready low holds RESP (outputs stable, req_ready low).
// Ports: req_* request channel (we/size/addr/wdata), resp_* response channel
// (rdata/err). Define DMEM_B2B_EN to accept a new request on the response
// handshake edge (no IDLE bubble between transactions).
module dmem_responder
  import dmem_pkg::*;
#(
  parameter int ADDR_WIDTH  = 5,
  parameter int DATA_WIDTH  = 32,
  parameter int WAIT_STATES = 2
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  req_valid,
  output logic                  req_ready,
  input  logic                  req_we,
  input  logic [2:0]            req_size,
  input  logic [31:0]           req_addr,
  input  logic [DATA_WIDTH-1:0] req_wdata,
  output logic                  resp_valid,
  input  logic                  resp_ready,
  output logic [DATA_WIDTH-1:0] resp_rdata,
  output logic                  resp_err
);

  localparam int DEPTH = 2 ** ADDR_WIDTH;

  state_e                state_q, state_d;
  logic [3:0]            cnt_q, cnt_d;
  logic                  we_q;
  logic [2:0]            size_q;
  logic [31:0]           addr_q;
  logic [DATA_WIDTH-1:0] wdata_q;
  logic [DATA_WIDTH-1:0] rdata_q, rdata_d;
  logic                  err_q;
  logic [DATA_WIDTH-1:0] mem_q [DEPTH];

  logic                  accept, commit, legal;
  logic                  op_we;
  logic [2:0]            op_size;
  logic [31:0]           op_addr;
  logic [DATA_WIDTH-1:0] op_wdata;
  logic [ADDR_WIDTH-1:0] idx;
  logic [3:0]            be;
  logic [31:0]           wdata_sh, rword, rdata_ext;
  logic                  unused_addr;

`ifdef DMEM_B2B_EN
  assign req_ready = (state_q == IDLE) || ((state_q == RESP) && resp_ready);
`else
  assign req_ready = (state_q == IDLE);
`endif

  assign accept     = req_valid && req_ready;
  assign resp_valid = (state_q == RESP);
  assign resp_rdata = rdata_q;
  assign resp_err   = err_q;

  // With zero wait states the commit edge is the accept edge, so the live
  // request must be used; otherwise the latched copy is (accept is 0 in WAIT).
  assign op_we    = accept ? req_we    : we_q;
  assign op_size  = accept ? req_size  : size_q;
  assign op_addr  = accept ? req_addr  : addr_q;
  assign op_wdata = accept ? req_wdata : wdata_q;

  // Upper address bits are deliberately ignored: accesses wrap modulo the array.
  assign idx         = op_addr[ADDR_WIDTH+1:2];
  assign unused_addr = ^op_addr[31:ADDR_WIDTH+2];
  assign legal       = is_legal(op_size, op_we, op_addr[1:0]);
  assign rword       = mem_q[idx];

  // Entering RESP (including RESP->RESP on a back-to-back accept) is the
  // single edge where the store lands and the load data is sampled.
  assign commit = (state_d == RESP) && ((state_q != RESP) || accept);

  dmem_lane_align u_align (
    .size_i    (op_size),
    .addr_lo_i (op_addr[1:0]),
    .wdata_i   (op_wdata),
    .rword_i   (rword),
    .be_o      (be),
    .wdata_o   (wdata_sh),
    .rdata_o   (rdata_ext)
  );

  assign rdata_d = (!legal || op_we) ? '0 : rdata_ext;

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    case (state_q)
      IDLE: begin
        if (accept) begin
          if (WAIT_STATES > 0) begin
            state_d = WAIT;
            cnt_d   = 4'(WAIT_STATES);
          end else begin
            state_d = RESP;
          end
        end
      end
      WAIT: begin
        cnt_d = cnt_q - 4'd1;
        if (cnt_q == 4'd1) state_d = RESP;
      end
      RESP: begin
        if (resp_ready) begin
`ifdef DMEM_B2B_EN
          if (accept) begin
            if (WAIT_STATES > 0) begin
              state_d = WAIT;
              cnt_d   = 4'(WAIT_STATES);
            end else begin
              state_d = RESP;
            end
          end else begin
            state_d = IDLE;
          end
`else
          state_d = IDLE;
`endif
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= IDLE;
      cnt_q   <= 4'd0;
      rdata_q <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      if (accept) begin
        we_q    <= req_we;
        size_q  <= req_size;
        addr_q  <= req_addr;
        wdata_q <= req_wdata;
      end
      if (commit) begin
        rdata_q <= rdata_d;
        err_q   <= ~legal;
      end
    end
  end

  // Array has no reset; a reset on the commit edge suppresses the write.
  always_ff @(posedge clk) begin
    if (rst_n && commit && legal && op_we) begin
      for (int i = 0; i < 4; i++) begin
        if (be[i]) mem_q[idx][8*i +: 8] <= wdata_sh[8*i +: 8];
      end
    end
  end

endmodule

// File: tb/tb_dmem_responder.sv
`timescale 1ns/1ps
module tb_dmem_responder;

  localparam int AW = 5;
  localparam int WS = 2;
`ifdef DMEM_B2B_EN
  localparam int SPACING = WS + 1;
`else
  localparam int SPACING = WS + 2;
`endif
  localparam logic [2:0] B = 3'b000, H = 3'b001, W = 3'b010, BU = 3'b100, HU = 3'b101;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        req_valid = 1'b0;
  logic        req_ready;
  logic        req_we = 1'b0;
  logic [2:0]  req_size = 3'b000;
  logic [31:0] req_addr = '0;
  logic [31:0] req_wdata = '0;
  logic        resp_valid;
  logic        resp_ready = 1'b1;
  logic [31:0] resp_rdata;
  logic        resp_err;

  dmem_responder #(.ADDR_WIDTH(AW), .DATA_WIDTH(32), .WAIT_STATES(WS)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .req_valid  (req_valid),
    .req_ready  (req_ready),
    .req_we     (req_we),
    .req_size   (req_size),
    .req_addr   (req_addr),
    .req_wdata  (req_wdata),
    .resp_valid (resp_valid),
    .resp_ready (resp_ready),
    .resp_rdata (resp_rdata),
    .resp_err   (resp_err)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc++;

  typedef struct {
    logic [31:0] rdata;
    logic        err;
    int          acc;
  } exp_t;

  exp_t sb[$];
  int   hs_cyc[$];
  int   tests = 0;
  int   fails = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Monitor: pops the scoreboard on each response handshake, checks latency on
  // first appearance and stability while the response is back-pressured.
  initial begin : monitor
    bit          seen;
    logic [31:0] snap_d;
    logic        snap_e;
    exp_t        e;
    seen = 1'b0;
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        seen = 1'b0;
      end else if (resp_valid) begin
        if (!seen) begin
          seen   = 1'b1;
          snap_d = resp_rdata;
          snap_e = resp_err;
          if (sb.size() > 0) check("latency", 32'(cyc + 1 - sb[0].acc), 32'(WS + 1));
        end else begin
          check("hold_rdata", resp_rdata, snap_d);
          check("hold_err", {31'd0, resp_err}, {31'd0, snap_e});
        end
        if (!resp_ready) check("req_ready_in_backpressure", {31'd0, req_ready}, 32'd0);
        if (resp_ready) begin
          if (sb.size() == 0) begin
            tests++;
            fails++;
            $display("FAIL unexpected_resp: got rdata 0x%08h err %0b, expected no response", resp_rdata, resp_err);
          end else begin
            e = sb.pop_front();
            check("resp_rdata", resp_rdata, e.rdata);
            check("resp_err", {31'd0, resp_err}, {31'd0, e.err});
          end
          hs_cyc.push_back(cyc + 1);
          seen = 1'b0;
        end
      end
    end
  end

  // Call at posedge+#1; returns at posedge+#1 after the accept edge.
  task automatic issue(input logic we, input logic [2:0] sz, input logic [31:0] a,
                       input logic [31:0] wd, input logic [31:0] erd, input logic eerr,
                       input bit push = 1'b1);
    int n = 0;
    req_valid = 1'b1;
    req_we    = we;
    req_size  = sz;
    req_addr  = a;
    req_wdata = wd;
    forever begin
      @(negedge clk);
      if (req_ready) break;
      n++;
      if (n > 50) break;
    end
    if (n > 50) begin
      tests++;
      fails++;
      $display("FAIL req_accept_timeout: got req_ready 0 for %0d cycles, expected 1", n);
    end else if (push) begin
      sb.push_back('{erd, eerr, cyc + 1});
    end
    @(posedge clk);
    #1 req_valid = 1'b0;
  endtask

  task automatic drain();
    int n = 0;
    while (sb.size() != 0 && n < 100) begin
      @(posedge clk);
      n++;
    end
    if (sb.size() != 0) begin
      tests++;
      fails++;
      $display("FAIL drain_timeout: got %0d pending responses, expected 0", sb.size());
      sb.delete();
    end
    @(posedge clk);
    #1;
  endtask

  initial begin
    // Reset values
    repeat (3) @(posedge clk);
    #1;
    check("rst_resp_valid", {31'd0, resp_valid}, 32'd0);
    check("rst_resp_err", {31'd0, resp_err}, 32'd0);
    check("rst_resp_rdata", resp_rdata, 32'd0);
    check("rst_req_ready", {31'd0, req_ready}, 32'd1);
    rst_n = 1'b1;
    @(posedge clk);
    #1;

    // Word store then load
    issue(1, W, 32'h08, 32'hDEADBEEF, 32'h0, 0);
    issue(0, W, 32'h08, 32'h0, 32'hDEADBEEF, 0);
    drain();

    // Sign/zero extension from word 0x80FF7F01
    issue(1, W,  32'h10, 32'h80FF7F01, 32'h0, 0);
    issue(0, B,  32'h11, 32'h0, 32'h0000007F, 0);
    issue(0, B,  32'h13, 32'h0, 32'hFFFFFF80, 0);
    issue(0, BU, 32'h13, 32'h0, 32'h00000080, 0);
    issue(0, H,  32'h12, 32'h0, 32'hFFFF80FF, 0);
    issue(0, HU, 32'h12, 32'h0, 32'h000080FF, 0);
    issue(0, B,  32'h12, 32'h0, 32'hFFFFFFFF, 0);
    issue(0, H,  32'h10, 32'h0, 32'h00007F01, 0);
    drain();

    // Partial-store merge
    issue(1, W, 32'h04, 32'h11223344, 32'h0, 0);
    issue(1, B, 32'h05, 32'h000000AA, 32'h0, 0);
    issue(1, H, 32'h06, 32'h0000BBCC, 32'h0, 0);
    issue(0, W, 32'h04, 32'h0, 32'hBBCCAA44, 0);
    drain();

    // Misaligned / illegal requests; errors must not write
    issue(1, W,      32'h0A, 32'h12345678, 32'h0, 1);
    issue(1, BU,     32'h08, 32'h00000055, 32'h0, 1);
    issue(0, W,      32'h08, 32'h0, 32'hDEADBEEF, 0);
    issue(0, H,      32'h03, 32'h0, 32'h0, 1);
    issue(0, HU,     32'h01, 32'h0, 32'h0, 1);
    issue(0, 3'b011, 32'h00, 32'h0, 32'h0, 1);
    issue(0, 3'b111, 32'h00, 32'h0, 32'h0, 1);
    drain();

    // Response backpressure: hold resp_ready low well past the response
    resp_ready = 1'b0;
    issue(0, W, 32'h10, 32'h0, 32'h80FF7F01, 0);
    repeat (WS + 6) @(posedge clk);
    #1 resp_ready = 1'b1;
    drain();

    // Reset while a store sits in WAIT: no response, no write
    issue(1, W, 32'h08, 32'hCAFEF00D, 32'h0, 0, 1'b0);
    rst_n = 1'b0;
    @(posedge clk);
    #1 rst_n = 1'b1;
    @(negedge clk);
    check("mid_rst_resp_valid", {31'd0, resp_valid}, 32'd0);
    check("mid_rst_req_ready", {31'd0, req_ready}, 32'd1);
    repeat (6) @(posedge clk);
    #1;
    issue(0, W, 32'h08, 32'h0, 32'hDEADBEEF, 0);
    drain();

    // Address wrap modulo the array
    issue(1, W, 32'h80, 32'h00000001, 32'h0, 0);
    issue(0, W, 32'h00, 32'h0, 32'h00000001, 0);
    issue(0, W, 32'h84, 32'h0, 32'hBBCCAA44, 0);
    drain();

    // Consecutive loads: check handshake spacing
    hs_cyc.delete();
    issue(0, W,  32'h08, 32'h0, 32'hDEADBEEF, 0);
    issue(0, W,  32'h10, 32'h0, 32'h80FF7F01, 0);
    issue(0, BU, 32'h04, 32'h0, 32'h00000044, 0);
    issue(0, W,  32'h00, 32'h0, 32'h00000001, 0);
    drain();
    check("b2b_resp_count", 32'(hs_cyc.size()), 32'd4);
    for (int i = 0; i + 1 < hs_cyc.size(); i++)
      check("b2b_spacing", 32'(hs_cyc[i+1] - hs_cyc[i]), 32'(SPACING));

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: got no finish by 200000 ns, expected completion");
    $fatal(1, "timeout");
  end

endmodule
